multicycle_controller: RTL

Multi-cycle control unit for the RV32I core. It replaces the purely combinational single-cycle decoder with a state machine that sequences FETCH, DECODE, EXEC, MEM and WB, and stalls on a ready handshake from the memory port. It also detects illegal encodings and memory timeouts and redirects the PC to a trap vector. It sits between the instruction register / memory interface and the datapath (ALU, register file, PC mux).

---
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle control FSM sequencing FETCH/DECODE/EXEC/MEM/WB/TRAP
// Ports: opcode/funct3/funct7 come from the instruction register, mem_ready is the memory handshake
//   and br_taken is the branch comparator result. The strobes are fetch_req, ir_en, pc_en, rf_en,
//   rd_en, wr_en and trap. The datapath selects are pc_sel, aluop, sel_a, sel_b, sel_wb, mem_mode
//   and br_type. mcause and state are status outputs.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       br_taken,
    output logic       fetch_req,
    output logic       ir_en,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic [3:0] aluop,
    output logic       rf_en,
    output logic       sel_a,
    output logic       sel_b,
    output logic [1:0] sel_wb,
    output logic       rd_en,
    output logic       wr_en,
    output logic [2:0] mem_mode,
    output logic [2:0] br_type,
    output logic       trap,
    output logic [1:0] mcause,
    output logic [2:0] state
);
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam int CW = TO_W > 0 ? TO_W : 1;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [3:0] {C_R, C_I, C_LD, C_ST, C_BR, C_LUI, C_AUIPC, C_JAL, C_JALR} cls_t;

    state_t        st, nxt;
    cls_t          cls, d_cls;
    logic [CW-1:0] cnt;
    logic [3:0]    d_alu, alu_f;
    logic          d_sa, d_sb, d_ill, timeout;
    logic [1:0]    d_wb;
    logic [2:0]    d_mm, d_bt;

    assign state = st;
    // Trap only when this cycle would bring the counter to the limit without a ready.
    assign timeout = MEM_TIMEOUT != 0 && !mem_ready && int'(cnt) + 1 >= MEM_TIMEOUT;

    always_comb begin
        alu_f = 4'd0;
        case (funct3)
            3'b000: alu_f = funct7[5] ? 4'd1 : 4'd0;
            3'b001: alu_f = 4'd2;
            3'b010: alu_f = 4'd3;
            3'b011: alu_f = 4'd4;
            3'b100: alu_f = 4'd5;
            3'b101: alu_f = funct7[5] ? 4'd7 : 4'd6;
            3'b110: alu_f = 4'd8;
            3'b111: alu_f = 4'd9;
            default: alu_f = 4'd0;
        endcase
    end

    always_comb begin
        d_cls = C_R;
        d_alu = 4'd0;
        d_sa  = 1'b0;
        d_sb  = 1'b1;
        d_wb  = 2'b00;
        d_mm  = 3'b000;
        d_bt  = 3'b000;
        d_ill = 1'b0;
        case (opcode)
            7'b0110011: begin
                d_sb  = 1'b0;
                d_alu = alu_f;
                d_ill = !(funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            7'b0010011: begin
                d_cls = C_I;
                d_alu = funct3 == 3'b000 ? 4'd0 : alu_f;
                d_ill = (funct3 == 3'b001 && funct7 != 7'h00) ||
                        (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20);
            end
            7'b0000011: begin
                d_cls = C_LD;
                d_wb  = 2'b01;
                d_mm  = funct3 == 3'b100 ? 3'd3 : funct3 == 3'b101 ? 3'd4 : funct3;
                d_ill = funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111;
            end
            7'b0100011: begin
                d_cls = C_ST;
                d_mm  = funct3;
                d_ill = funct3 > 3'b010;
            end
            7'b1100011: begin
                d_cls = C_BR;
                d_sa  = 1'b1;
                d_bt  = funct3;
                d_ill = funct3 == 3'b010 || funct3 == 3'b011;
            end
            7'b0110111: begin
                d_cls = C_LUI;
                d_alu = 4'd10;
            end
            7'b0010111: begin
                d_cls = C_AUIPC;
                d_sa  = 1'b1;
            end
            7'b1101111: begin
                d_cls = C_JAL;
                d_sa  = 1'b1;
                d_wb  = 2'b10;
            end
            7'b1100111: begin
                d_cls = C_JALR;
                d_wb  = 2'b10;
                d_ill = funct3 != 3'b000;
            end
            default: d_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= FETCH;
        else     st <= nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            mcause   <= 2'b00;
            cls      <= C_R;
            aluop    <= 4'd0;
            sel_a    <= 1'b0;
            sel_b    <= 1'b0;
            sel_wb   <= 2'b00;
            mem_mode <= 3'b000;
            br_type  <= 3'b000;
        end else begin
            // Every state change clears the counter, which covers entry to FETCH and MEM.
            cnt <= nxt != st ? '0 : (!mem_ready && int'(cnt) < MEM_TIMEOUT) ? cnt + 1'b1 : cnt;
            if (nxt == TRAP && st != TRAP) mcause <= st == DECODE ? 2'b01 : 2'b10;
            if (st == DECODE) begin
                cls      <= d_cls;
                aluop    <= d_alu;
                sel_a    <= d_sa;
                sel_b    <= d_sb;
                sel_wb   <= d_wb;
                mem_mode <= d_mm;
                br_type  <= d_bt;
            end
        end
    end

    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:  nxt = mem_ready ? DECODE : timeout ? TRAP : FETCH;
            DECODE: nxt = d_ill ? TRAP : EXEC;
            EXEC:   nxt = cls == C_BR ? FETCH : (cls == C_LD || cls == C_ST) ? MEM : WB;
            MEM:    nxt = mem_ready ? (cls == C_LD ? WB : FETCH) : timeout ? TRAP : MEM;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        fetch_req = !rst && st == FETCH;
        ir_en     = !rst && st == FETCH && mem_ready;
        rd_en     = !rst && st == MEM && cls == C_LD;
        wr_en     = !rst && st == MEM && cls == C_ST;
        rf_en     = !rst && st == WB;
        trap      = !rst && st == TRAP;
        pc_en     = !rst && (st == WB || st == TRAP || (st == EXEC && cls == C_BR) ||
                             (st == MEM && cls == C_ST && mem_ready));
        pc_sel    = st == TRAP ? 2'b10 :
                    ((st == EXEC && cls == C_BR && br_taken) ||
                     (st == WB && (cls == C_JAL || cls == C_JALR))) ? 2'b01 : 2'b00;
    end
endmodule
